// File: rtl/prbs7_checker.sv
// prbs7_checker
//   Receive-end checker for a PRBS7 (x^7 + x^6 + 1) serial stream.
//   It self-synchronises a local copy of the sequence from the received
//   bits (HUNT), confirms the copy by predicting SYNC_LEN bits in a row
//   (VERIFY), then free-runs the copy and counts mismatches (LOCK).
//   Too many errors inside one WIN-bit window drops back to HUNT.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           bit-valid strobe; d_in is used only on edges with en=1
//   d_in         received serial bit
//   clear        synchronous clear of err_count
//   locked       1 while in LOCK
//   state        00 HUNT, 01 VERIFY, 10 LOCK
//   err_pulse    one-cycle pulse per bit error seen in LOCK
//   err_count    saturating error counter
//   period_pulse one-cycle pulse each time the locked copy wraps to 7'h7F
module prbs7_checker #(
  parameter int SYNC_LEN = 16,
  parameter int WIN      = 32,
  parameter int LOSS_THR = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d_in,
  input  logic             clear,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             period_pulse
);

  localparam logic [1:0] ST_HUNT   = 2'b00;
  localparam logic [1:0] ST_VERIFY = 2'b01;
  localparam logic [1:0] ST_LOCK   = 2'b10;

  localparam logic [8:0]       SYNC_LEN_C = 9'(SYNC_LEN);
  localparam logic [8:0]       WIN_LAST_C = 9'(WIN - 1);
  localparam logic [8:0]       LOSS_THR_C = 9'(LOSS_THR);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [6:0]       s_q, s_d;
  logic [2:0]       fill_q, fill_d;
  logic [8:0]       match_q, match_d;
  logic [8:0]       win_cnt_q, win_cnt_d;
  logic [8:0]       win_err_q, win_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             period_pulse_q, period_pulse_d;

  logic       pred;
  logic       mism;
  logic [6:0] s_shift_rx;
  logic [6:0] s_shift_fw;
  logic       fill_last;
  logic       match_last;
  logic [8:0] win_err_inc;
  logic       win_last;
  logic       lose_lock;

  assign pred        = s_q[6] ^ s_q[5];
  assign mism        = d_in ^ pred;
  assign s_shift_rx  = {s_q[5:0], d_in};
  assign s_shift_fw  = {s_q[5:0], pred};
  assign fill_last   = (fill_q == 3'd6);
  assign match_last  = ((match_q + 9'd1) == SYNC_LEN_C);
  assign win_err_inc = win_err_q + {8'd0, mism};
  assign win_last    = (win_cnt_q == WIN_LAST_C);
  // The threshold includes the current bit, so it wins over a window wrap.
  assign lose_lock   = mism && (win_err_inc >= LOSS_THR_C);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: begin
        // An all-zero register is the PRBS lock-up state; keep hunting.
        if (en && fill_last && (s_shift_rx != 7'd0)) state_d = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (en) begin
          if (mism)            state_d = ST_HUNT;
          else if (match_last) state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (en && lose_lock) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // Output logic
  always_comb begin
    locked       = (state_q == ST_LOCK);
    state        = (state_q == 2'b11) ? ST_HUNT : state_q;
    err_pulse    = err_pulse_q;
    period_pulse = period_pulse_q;
    err_count    = err_cnt_q;
  end

  // Datapath next values
  always_comb begin
    s_d            = s_q;
    fill_d         = fill_q;
    match_d        = match_q;
    win_cnt_d      = win_cnt_q;
    win_err_d      = win_err_q;
    err_pulse_d    = 1'b0;
    period_pulse_d = 1'b0;
    if (en) begin
      case (state_q)
        ST_HUNT: begin
          s_d     = s_shift_rx;
          fill_d  = fill_last ? 3'd0 : fill_q + 3'd1;
          match_d = 9'd0;
        end
        ST_VERIFY: begin
          s_d = s_shift_rx;
          if (mism) begin
            // The offending bit counts as the first bit of the new hunt.
            fill_d = 3'd1;
          end else begin
            match_d = match_q + 9'd1;
            if (match_last) begin
              win_cnt_d = 9'd0;
              win_err_d = 9'd0;
            end
          end
        end
        ST_LOCK: begin
          // Flywheel: the local copy runs on its own predictions only.
          s_d            = s_shift_fw;
          err_pulse_d    = mism;
          period_pulse_d = (s_shift_fw == 7'h7F);
          if (lose_lock) begin
            s_d       = 7'd0;
            fill_d    = 3'd0;
            win_cnt_d = 9'd0;
            win_err_d = 9'd0;
          end else if (win_last) begin
            win_cnt_d = 9'd0;
            win_err_d = 9'd0;
          end else begin
            win_cnt_d = win_cnt_q + 9'd1;
            win_err_d = win_err_inc;
          end
        end
        default: begin
          s_d    = 7'd0;
          fill_d = 3'd0;
        end
      endcase
    end
  end

  // Error counter: a clear that lands on a counted error keeps that error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear) begin
      err_cnt_d = ERR_W'(err_pulse_d);
    end else if (err_pulse_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q            <= 7'd0;
      fill_q         <= 3'd0;
      match_q        <= 9'd0;
      win_cnt_q      <= 9'd0;
      win_err_q      <= 9'd0;
      err_cnt_q      <= '0;
      err_pulse_q    <= 1'b0;
      period_pulse_q <= 1'b0;
    end else begin
      s_q            <= s_d;
      fill_q         <= fill_d;
      match_q        <= match_d;
      win_cnt_q      <= win_cnt_d;
      win_err_q      <= win_err_d;
      err_cnt_q      <= err_cnt_d;
      err_pulse_q    <= err_pulse_d;
      period_pulse_q <= period_pulse_d;
    end
  end

endmodule

// File: tb/tb_prbs7_checker.sv
module tb_prbs7_checker;

  localparam int SYNC_LEN = 16;
  localparam int WIN      = 32;
  localparam int LOSS_THR = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       d_in;
  logic       clear;
  logic       locked8, locked4;
  logic [1:0] state8, state4;
  logic       ep8, ep4, pp8, pp4;
  logic [7:0] cnt8;
  logic [3:0] cnt4;

  prbs7_checker #(.SYNC_LEN(SYNC_LEN), .WIN(WIN), .LOSS_THR(LOSS_THR), .ERR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in), .clear(clear),
    .locked(locked8), .state(state8), .err_pulse(ep8), .err_count(cnt8),
    .period_pulse(pp8)
  );

  prbs7_checker #(.SYNC_LEN(SYNC_LEN), .WIN(WIN), .LOSS_THR(LOSS_THR), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in), .clear(clear),
    .locked(locked4), .state(state4), .err_pulse(ep4), .err_count(cnt4),
    .period_pulse(pp4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode 0 = hunting, 1 = verifying, 2 = locked. The local sequence is kept
  // as a queue of the last seven bits, oldest first.
  int m_mode, m_fill, m_match, m_win, m_werr, m_cnt8, m_cnt4;
  bit m_ep, m_pp;
  bit m_q[$];

  function automatic int q_ones();
    int n = 0;
    foreach (m_q[i]) n += int'(m_q[i]);
    return n;
  endfunction

  function automatic void q_zero();
    m_q = {};
    for (int i = 0; i < 7; i++) m_q.push_back(1'b0);
  endfunction

  function automatic void model_reset();
    q_zero();
    m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_cnt8 = 0; m_cnt4 = 0; m_ep = 0; m_pp = 0;
  endfunction

  function automatic void model_step(bit e, bit d, bit c);
    bit p;
    bit counted;
    counted = 0;
    m_ep = 0;
    m_pp = 0;
    if (e) begin
      // Next PRBS bit = bit seven back XOR bit six back.
      p = m_q[0] ^ m_q[1];
      if (m_mode == 0) begin
        m_q.push_back(d); void'(m_q.pop_front());
        m_fill++;
        if (m_fill == 7) begin
          m_fill = 0;
          if (q_ones() != 0) begin m_mode = 1; m_match = 0; end
        end
      end else if (m_mode == 1) begin
        m_q.push_back(d); void'(m_q.pop_front());
        if (d == p) begin
          m_match++;
          if (m_match == SYNC_LEN) begin m_mode = 2; m_win = 0; m_werr = 0; end
        end else begin
          m_mode = 0; m_fill = 1;
        end
      end else begin
        m_q.push_back(p); void'(m_q.pop_front());
        m_pp = (q_ones() == 7);
        if (d != p) begin counted = 1; m_ep = 1; m_werr++; end
        if (counted && m_werr >= LOSS_THR) begin
          m_mode = 0; m_fill = 0; q_zero();
        end else if (m_win == WIN - 1) begin
          m_win = 0; m_werr = 0;
        end else begin
          m_win++;
        end
      end
    end
    if (c) begin
      m_cnt8 = int'(counted);
      m_cnt4 = int'(counted);
    end else if (counted) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [6:0] g;

  function automatic bit gen_bit();
    bit b;
    b = g[6] ^ g[5];
    g = {g[5:0], b};
    return b;
  endfunction

  task automatic step(input bit e, input bit d, input bit c, input string tag);
    logic [14:0] a8, x8;
    logic [10:0] a4, x4;
    en = e; d_in = d; clear = c;
    @(posedge clk);
    model_step(e, d, c);
    #1;
    a8 = {state8, locked8, ep8, pp8, cnt8};
    x8 = {2'(m_mode), (m_mode == 2), m_ep, m_pp, 8'(m_cnt8)};
    a4 = {state4, locked4, ep4, pp4, cnt4};
    x4 = {2'(m_mode), (m_mode == 2), m_ep, m_pp, 4'(m_cnt4)};
    chk({tag, "_model8"}, 32'(a8), 32'(x8));
    chk({tag, "_model4"}, 32'(a4), 32'(x4));
  endtask

  task automatic do_reset();
    en = 0; d_in = 0; clear = 0; rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    chk("reset_outputs8", 32'({state8, locked8, ep8, pp8, cnt8}), 32'd0);
    chk("reset_outputs4", 32'({state4, locked4, ep4, pp4, cnt4}), 32'd0);
  endtask

  typedef struct {
    bit       en;
    bit       d;
    bit       clr;
    bit [1:0] st;
    bit       lk;
    bit       ep;
    bit       pp;
    int       cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit b;
    int last_pp, npp, acc, pcount, nerr, sum_ep;
    bit e, ever_nz;

    // HUNT/VERIFY entry and exit from a zero register, first bits of the
    // seed-7F sequence are 0,0,0,0,0,0,1.
    tbl[0]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 2'b00, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 2'b01, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 2'b01, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 2'b01, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 2'b01, 0, 0, 0, 0};
    tbl[11] = '{1, 1, 0, 2'b00, 0, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].d, tbl[i].clr, "tbl");
      chk($sformatf("tbl_row%0d", i), 32'({state8, locked8, ep8, pp8, cnt8}),
          32'({tbl[i].st, tbl[i].lk, tbl[i].ep, tbl[i].pp, 8'(tbl[i].cnt)}));
    end

    // Clean stream, en every cycle
    do_reset();
    g = 7'h7F; last_pp = -1; npp = 0;
    for (int i = 1; i <= 300; i++) begin
      b = gen_bit();
      step(1, b, 0, "clean");
      if (i == 6)  chk("clean_hunt_at_6", 32'(state8), 32'd0);
      if (i == 7)  chk("clean_verify_at_7", 32'(state8), 32'd1);
      if (i == 22) chk("clean_verify_at_22", 32'(state8), 32'd1);
      if (i == 23) chk("clean_lock_at_23", 32'({state8, locked8}), 32'b101);
      if (pp8) begin
        if (last_pp < 0) chk("clean_first_period", 32'(i), 32'd127);
        else             chk("clean_period_gap", 32'(i - last_pp), 32'd127);
        last_pp = i;
        npp++;
      end
    end
    chk("clean_period_count", 32'(npp), 32'd2);
    chk("clean_err_count", 32'(cnt8), 32'd0);

    // Clean stream with en toggling; random data on idle cycles
    do_reset();
    g = 7'h7F; acc = 0; pcount = 0;
    for (int cyc = 0; cyc < 2000 && acc < 260; cyc++) begin
      e = (cyc % 2 == 0);
      if (e) begin b = gen_bit(); acc++; end
      else   b = 1'($urandom);
      step(e, b, 0, "toggle");
      if (e && acc == 7)  chk("toggle_verify_at_7", 32'(state8), 32'd1);
      if (e && acc == 23) chk("toggle_lock_at_23", 32'(state8), 32'd2);
      if (pp8) begin
        pcount++;
        chk("toggle_period_acc", 32'(acc), 32'(127 * pcount));
      end
    end
    chk("toggle_period_count", 32'(pcount), 32'd2);

    // Single error while locked
    b = gen_bit();
    step(1, !b, 0, "single");
    chk("single_pulse", 32'({ep8, cnt8, locked8}), 32'({1'b1, 8'd1, 1'b1}));
    sum_ep = 0;
    for (int i = 0; i < 126; i++) begin
      b = gen_bit();
      step(1, b, 0, "single_after");
      sum_ep += int'(ep8);
      if (i == 0) chk("single_pulse_gone", 32'(ep8), 32'd0);
    end
    chk("single_no_more_err", 32'(sum_ep), 32'd0);
    chk("single_count_held", 32'({cnt8, locked8}), 32'({8'd1, 1'b1}));
    b = gen_bit();
    step(1, !b, 1, "clear_err");
    chk("clear_with_error", 32'({cnt8, ep8}), 32'({8'd1, 1'b1}));
    b = gen_bit();
    step(1, b, 1, "clear_alone");
    chk("clear_alone8", 32'(cnt8), 32'd0);
    chk("clear_alone4", 32'(cnt4), 32'd0);

    // Four errors in one window drop lock, then relock
    do_reset();
    g = 7'h7F;
    for (int i = 1; i <= 23; i++) begin b = gen_bit(); step(1, b, 0, "loss_sync"); end
    chk("loss_locked", 32'(locked8), 32'd1);
    for (int k = 0; k <= 6; k++) begin
      b = gen_bit();
      step(1, (k % 2 == 0) ? !b : b, 0, "loss");
      if (k == 4) chk("loss_still_locked", 32'(state8), 32'd2);
    end
    chk("loss_state", 32'({state8, locked8, ep8}), 32'b001);
    chk("loss_count", 32'(cnt8), 32'd4);
    for (int j = 1; j <= 23; j++) begin
      b = gen_bit();
      step(1, b, 0, "relock");
      if (j == 7)  chk("relock_verify", 32'(state8), 32'd1);
      if (j == 22) chk("relock_not_yet", 32'(state8), 32'd1);
      if (j == 23) chk("relock_lock", 32'(state8), 32'd2);
    end

    // All-zero input never leaves HUNT
    do_reset();
    ever_nz = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1, 0, 0, "zeros");
      if (state8 != 2'b00) ever_nz = 1;
    end
    chk("zeros_stay_hunt", 32'(ever_nz), 32'd0);

    // Error on the 12th VERIFY bit
    do_reset();
    g = 7'h7F;
    for (int i = 1; i <= 60; i++) begin
      b = gen_bit();
      step(1, (i == 19) ? !b : b, 0, "verr");
      if (i == 18) chk("verr_verify_18", 32'(state8), 32'd1);
      if (i == 19) chk("verr_hunt_19", 32'(state8), 32'd0);
      if (i == 25) chk("verr_verify_25", 32'(state8), 32'd1);
      if (i == 26) chk("verr_hunt_26", 32'(state8), 32'd0);
      if (i == 32) chk("verr_verify_32", 32'(state8), 32'd1);
      if (i == 47) chk("verr_verify_47", 32'(state8), 32'd1);
      if (i == 48) chk("verr_lock_48", 32'(state8), 32'd2);
    end

    // Saturation: 20 errors, two per window
    do_reset();
    g = 7'h7F;
    for (int i = 1; i <= 23; i++) begin b = gen_bit(); step(1, b, 0, "sat_sync"); end
    nerr = 0;
    for (int i = 1; i <= 320; i++) begin
      b = gen_bit();
      step(1, (i % 16 == 0) ? !b : b, 0, "sat");
      nerr += int'(ep8);
    end
    chk("sat_pulses", 32'(nerr), 32'd20);
    chk("sat_count4", 32'(cnt4), 32'd15);
    chk("sat_count8", 32'(cnt8), 32'd20);
    chk("sat_locked", 32'(locked4), 32'd1);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 0;
    #1;
    chk("async_reset8", 32'({state8, locked8, ep8, pp8, cnt8}), 32'd0);
    chk("async_reset4", 32'({state4, locked4, ep4, pp4, cnt4}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    b = gen_bit();
    step(1, b, 0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
